// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-side fields, hazard requests,
// fetch enables and the registered EX-side view.
interface id_ex_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              bubble;
  logic              flush;
  logic              id_valid;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [7:0]        id_ctrl;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              ex_valid;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [7:0]        ex_ctrl;
  logic              ex_mem_read;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output bubble, flush, id_valid,
    output id_rs, id_rt, id_rd,
    output id_rs_data, id_rt_data, id_imm, id_ctrl,
    input  pc_write, if_id_write, if_id_flush,
    input  ex_valid, ex_rs, ex_rt, ex_rd,
    input  ex_rs_data, ex_rt_data, ex_imm, ex_ctrl,
    input  ex_mem_read, state, stall_count, flush_count
  );

  modport slave (
    input  bubble, flush, id_valid,
    input  id_rs, id_rt, id_rd,
    input  id_rs_data, id_rt_data, id_imm, id_ctrl,
    output pc_write, if_id_write, if_id_flush,
    output ex_valid, ex_rs, ex_rt, ex_rd,
    output ex_rs_data, ex_rt_data, ex_imm, ex_ctrl,
    output ex_mem_read, state, stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble / branch flush
// handling and saturating stall/flush event counters.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_reg_if.slave  bus
);
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    FLUSH  = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              valid_q;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [7:0]        ctrl_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic stall;
  logic nop;

  assign stall = bus.bubble & ~bus.flush;
  assign nop   = bus.bubble | bus.flush;

  assign bus.pc_write    = ~stall;
  assign bus.if_id_write = ~stall;
  assign bus.if_id_flush = bus.flush;

  // flush outranks bubble
  always_comb begin
    state_d = RUN;
    priority case (1'b1)
      bus.flush:  state_d = FLUSH;
      bus.bubble: state_d = BUBBLE;
      default:    state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // a NOP clears rd and mem_read so the bubble drops next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else if (nop) begin
      valid_q   <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= bus.id_valid;
      rs_q      <= bus.id_rs;
      rt_q      <= bus.id_rt;
      rd_q      <= bus.id_rd;
      rs_data_q <= bus.id_rs_data;
      rt_data_q <= bus.id_rt_data;
      imm_q     <= bus.id_imm;
      ctrl_q    <= bus.id_valid ? bus.id_ctrl : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (bus.flush && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_rs       = rs_q;
  assign bus.ex_rt       = rt_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_rs_data  = rs_data_q;
  assign bus.ex_rt_data  = rt_data_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_ctrl     = ctrl_q;
  assign bus.ex_mem_read = ctrl_q[6] & valid_q;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load-use bubble,
// flush, bubble+flush, counter saturation, async reset.
module tb_id_ex_reg;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  id_ex_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  id_ex_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [7:0] ctrl, input logic [31:0] dat);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = rd;
    bus.id_ctrl    = ctrl;
    bus.id_rs_data = dat;
    bus.id_rt_data = ~dat;
    bus.id_imm     = dat + 32'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.bubble = 1'b0;
    bus.flush  = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 5'd7, 8'hFF, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      bus.flush = i[0];
      step();
    end
    bus.flush  = 1'b0;
    bus.bubble = 1'b1;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 ||
        bus.ex_ctrl !== 8'h00 || bus.ex_imm !== 32'd0) begin
      $display("FAIL reset_regs: valid=%b rd=%0d ctrl=%h imm=%h want 0",
               bus.ex_valid, bus.ex_rd, bus.ex_ctrl, bus.ex_imm);
      errors++;
    end
    checks++;
    if (bus.state !== 2'b00 || bus.stall_count !== 4'd0 ||
        bus.flush_count !== 4'd0) begin
      $display("FAIL reset_state: state=%b stall=%0d flush=%0d want 0",
               bus.state, bus.stall_count, bus.flush_count);
      errors++;
    end
    checks++;
    if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0) begin
      $display("FAIL reset_comb_en: pc_write=%b if_id_write=%b want 0",
               bus.pc_write, bus.if_id_write);
      errors++;
    end
    bus.bubble = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd5, 8'h80, 32'h0000_0010);
    step();
    checks++;
    if (bus.ex_rd !== 5'd5 || bus.ex_valid !== 1'b1 ||
        bus.ex_ctrl !== 8'h80) begin
      $display("FAIL post_reset_load: rd=%0d valid=%b ctrl=%h want 5 1 80",
               bus.ex_rd, bus.ex_valid, bus.ex_ctrl);
      errors++;
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd2, 5'd3, 5'd3, 8'hC0, 32'h0000_0100);
    step();
    checks++;
    if (bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd3 ||
        bus.ex_rs_data !== 32'h0000_0100) begin
      $display("FAIL load_in_ex: mr=%b rd=%0d rsd=%h want 1 3 00000100",
               bus.ex_mem_read, bus.ex_rd, bus.ex_rs_data);
      errors++;
    end
    drive(1'b1, 5'd3, 5'd4, 5'd6, 8'h82, 32'h1234_5678);
    bus.bubble = 1'b1;
    #1;
    checks++;
    if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0 ||
        bus.if_id_flush !== 1'b0) begin
      $display("FAIL bubble_comb: pc=%b ifid=%b fl=%b want 0 0 0",
               bus.pc_write, bus.if_id_write, bus.if_id_flush);
      errors++;
    end
    step();
    bus.bubble = 1'b0;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 ||
        bus.ex_rd !== 5'd0 || bus.state !== 2'b01 ||
        bus.stall_count !== 4'd1) begin
      $display("FAIL bubble_nop: v=%b mr=%b rd=%0d st=%b sc=%0d want 0 0 0 01 1",
               bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.state,
               bus.stall_count);
      errors++;
    end
    step();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd3 ||
        bus.ex_rt !== 5'd4 || bus.ex_rd !== 5'd6 ||
        bus.ex_ctrl !== 8'h82 || bus.ex_rt_data !== 32'hEDCB_A987 ||
        bus.ex_imm !== 32'h1234_5679 || bus.state !== 2'b00) begin
      $display("FAIL add_after_bubble: v=%b rs=%0d rt=%0d rd=%0d ctrl=%h rtd=%h imm=%h st=%b",
               bus.ex_valid, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_ctrl,
               bus.ex_rt_data, bus.ex_imm, bus.state);
      errors++;
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd9, 5'd10, 5'd11, 8'h88, 32'h0000_00AA);
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.if_id_flush !== 1'b1 || bus.pc_write !== 1'b1) begin
      $display("FAIL flush_comb: fl=%b pc=%b want 1 1",
               bus.if_id_flush, bus.pc_write);
      errors++;
    end
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 ||
        bus.ex_rs !== 5'd0 || bus.ex_rd !== 5'd0 ||
        bus.state !== 2'b10 || bus.flush_count !== 4'd1) begin
      $display("FAIL flush_nop: v=%b ctrl=%h rs=%0d rd=%0d st=%b fc=%0d want 0 00 0 0 10 1",
               bus.ex_valid, bus.ex_ctrl, bus.ex_rs, bus.ex_rd, bus.state,
               bus.flush_count);
      errors++;
    end
  endtask

  task automatic test_bubble_and_flush();
    bus.bubble = 1'b1;
    bus.flush  = 1'b1;
    #1;
    checks++;
    if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1 ||
        bus.if_id_flush !== 1'b1) begin
      $display("FAIL both_comb: pc=%b ifid=%b fl=%b want 1 1 1",
               bus.pc_write, bus.if_id_write, bus.if_id_flush);
      errors++;
    end
    step();
    bus.bubble = 1'b0;
    bus.flush  = 1'b0;
    checks++;
    if (bus.flush_count !== 4'd2 || bus.stall_count !== 4'd1 ||
        bus.state !== 2'b10 || bus.ex_valid !== 1'b0) begin
      $display("FAIL both_edge: fc=%0d sc=%0d st=%b v=%b want 2 1 10 0",
               bus.flush_count, bus.stall_count, bus.state, bus.ex_valid);
      errors++;
    end
  endtask

  task automatic test_invalid_id();
    drive(1'b0, 5'd1, 5'd2, 5'd12, 8'hFF, 32'h5);
    step();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 8'h00 ||
        bus.ex_mem_read !== 1'b0 || bus.ex_rd !== 5'd12 ||
        bus.state !== 2'b00) begin
      $display("FAIL invalid_id: v=%b ctrl=%h mr=%b rd=%0d st=%b want 0 00 0 12 00",
               bus.ex_valid, bus.ex_ctrl, bus.ex_mem_read, bus.ex_rd,
               bus.state);
      errors++;
    end
  endtask

  task automatic test_saturation();
    bus.bubble = 1'b1;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (bus.stall_count !== 4'd15 || bus.flush_count !== 4'd2) begin
      $display("FAIL sat_reach: sc=%0d fc=%0d want 15 2",
               bus.stall_count, bus.flush_count);
      errors++;
    end
    step();
    checks++;
    if (bus.stall_count !== 4'd15 || bus.state !== 2'b01) begin
      $display("FAIL sat_hold: sc=%0d st=%b want 15 01",
               bus.stall_count, bus.state);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd7, 5'd8, 5'd9, 8'hC1, 32'h77);
    bus.bubble = 1'b0;
    step();
    bus.bubble = 1'b1;
    step();
    checks++;
    if (bus.state !== 2'b01) begin
      $display("FAIL pre_async: st=%b want 01", bus.state);
      errors++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 2'b00 || bus.stall_count !== 4'd0 ||
        bus.flush_count !== 4'd0 || bus.ex_valid !== 1'b0 ||
        bus.ex_rd !== 5'd0 || bus.ex_imm !== 32'd0) begin
      $display("FAIL async_clear: st=%b sc=%0d fc=%0d v=%b rd=%0d imm=%h want all 0",
               bus.state, bus.stall_count, bus.flush_count, bus.ex_valid,
               bus.ex_rd, bus.ex_imm);
      errors++;
    end
    step();
    bus.bubble = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd13, 8'h80, 32'h99);
    step();
    checks++;
    if (bus.state !== 2'b00 || bus.ex_rd !== 5'd13 ||
        bus.ex_valid !== 1'b1 || bus.stall_count !== 4'd0) begin
      $display("FAIL after_async: st=%b rd=%0d v=%b sc=%0d want 00 13 1 0",
               bus.state, bus.ex_rd, bus.ex_valid, bus.stall_count);
      errors++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load_use();
    test_flush();
    test_bubble_and_flush();
    test_invalid_id();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the 5-stage MIPS core. It is the consumer side of the load-use hazard handshake: it takes the hazard detector's `bubble` request and the EX-stage branch `flush`, and turns them into PC/IF-ID write enables and a NOP injected into EX. It feeds `ex_mem_read`/`ex_rd` back to the hazard detector, and it keeps saturating stall and flush counters for performance monitoring.

## Interface
- `DATA_W`, 32, width of operand/immediate datapath
- `CNT_W`, 16, width of stall/flush counters
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `bubble`  in  1  load-use stall request from hazard detector (combinational, same cycle)
- `flush`  in  1  branch/jump taken in EX; squash instruction currently in ID
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  5 each  ID register specifiers (`id_rd` = final write destination)
- `id_rs_data`, `id_rt_data`, `id_imm`  in  DATA_W each  register-file reads, sign-extended immediate
- `id_ctrl`  in  8  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op[2:0]}
- `pc_write`  out  1  PC load enable
- `if_id_write`  out  1  IF/ID register load enable
- `if_id_flush`  out  1  IF/ID register clear (insert NOP into ID)
- `ex_valid`  out  1  EX holds a real instruction
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  registered specifiers
- `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  DATA_W each  registered operands
- `ex_ctrl`  out  8  registered control, same packing as `id_ctrl`
- `ex_mem_read`  out  1  `ex_ctrl[6] & ex_valid`; returned to hazard detector
- `state`  out  2  00 RUN, 01 BUBBLE, 10 FLUSH
- `stall_count`, `flush_count`  out  CNT_W each  saturating event counters

## Operation
- Priority: `flush` > `bubble` > normal advance.
- Combinational enables:
  - `pc_write = if_id_write = ~(bubble & ~flush)`.
  - `if_id_flush = flush`.
- Register update at each rising edge:
  - flush=1: load NOP.
  - bubble=1, flush=0: load NOP. The IF/ID contents are held upstream because `if_id_write`=0.
  - Otherwise: load all `id_*` fields. Set `ex_valid = id_valid`. When `id_valid`=0, force `ex_ctrl` to 0.
- NOP definition: `ex_valid`=0, `ex_ctrl`=0, `ex_rs`/`ex_rt`/`ex_rd`=0. Data fields are don't-care; the implementation loads them with 0.
- Zeroing `ex_rd` and `ex_mem_read` on a NOP guarantees the hazard detector drops `bubble` in the next cycle. A load-use stall therefore lasts exactly one cycle.
- FSM: next state = FLUSH if flush, else BUBBLE if bubble, else RUN. `state` shows what was loaded at the last edge. There are no other transitions and no illegal-state hold; encoding 11 returns to RUN.
- Counters:
  - `stall_count` +1 on each edge with bubble & ~flush.
  - `flush_count` +1 on each edge with flush.
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, active low): all registered outputs 0, `state`=RUN, counters 0. While reset is held, `pc_write`/`if_id_write` still follow the combinational equation. Reset asserted mid-stall discards the pending NOP/hold. After release, the block resumes in RUN with EX empty.

## Timing
- ID to EX latency is 1 cycle.
- Enables and `if_id_flush` are purely combinational from `bubble`/`flush`, with zero latency in the same cycle.
- `ex_mem_read` and `ex_rd` are registered outputs, which breaks the `bubble` combinational loop.
- Consecutive `bubble` cycles are each honoured: one NOP per cycle and one count per cycle.
- `bubble` and `flush` in the same cycle: flush wins. `pc_write`=1, `if_id_flush`=1, `flush_count`+1, `stall_count` unchanged, `state`=FLUSH.

## Test plan
- Reset: with `rst_n`=0 while inputs toggle, all registered outputs stay 0 and `state`=00. Release, drive `id_valid`=1, `id_rd`=5, `id_ctrl`=8'h80: next edge gives `ex_rd`=5, `ex_valid`=1.
- Load-use: load with `id_ctrl`=8'hC0, `id_rd`=3 enters EX. Hazard detector raises `bubble` on a dependent `add`:
  - Same cycle: `pc_write`=`if_id_write`=0.
  - Next edge: `ex_valid`=0, `ex_mem_read`=0, `state`=01, `stall_count`=1.
  - Following edge: the `add` fields appear in EX.
- Flush: `flush`=1 for one cycle gives `if_id_flush`=1 that cycle. Next edge: EX holds NOP, `state`=10, `flush_count`=1.
- Simultaneous `bubble`=`flush`=1: `pc_write`=1, `flush_count`+1, `stall_count` unchanged, `state`=10.
- Saturation: preload via 2^CNT_W−1 stall cycles (or CNT_W=4 override). One more bubble leaves `stall_count`=all-ones.
- Async reset mid-stall: assert `rst_n`=0 between edges while `state`=01. Outputs clear immediately without waiting for a clock edge, and `state`=00.
